// File: rtl/digct_stim_seq.sv
// Vector sequencer: replays up to DEPTH stored W-bit patterns on VEC, each held HOLD cycles.
// Latency: START/STOP act on the edge that samples them; all outputs are registered.
// Backpressure: none; writes while BUSY are dropped, START while running is ignored.
//
// Ports:
//   CLK, RST (async active-low)
//   WR_EN/WR_ADDR/WR_DATA : pattern write port, honoured only while not BUSY
//   LAST                  : final vector index, captured when a run starts
//   START/STOP/LOOP       : run control (STOP has priority over START)
//   VEC/VEC_VALID/IDX     : current vector, its validity and index
//   BUSY/DONE             : running / non-loop sequence finished (sticky)
module digct_stim_seq #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int W     = 5,
  parameter int HOLD  = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [W-1:0]  WR_DATA,
  input  logic [AW-1:0] LAST,
  input  logic          START,
  input  logic          STOP,
  input  logic          LOOP,
  output logic [W-1:0]  VEC,
  output logic          VEC_VALID,
  output logic [AW-1:0] IDX,
  output logic          BUSY,
  output logic          DONE
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_e;

  state_e        state_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] last_q;
  logic [AW-1:0] idx_q;
  logic [HW-1:0] hcnt_q;
  logic [W-1:0]  vec_q;
  logic          vld_q;
  logic          busy_q;
  logic          done_q;

  logic          wr_acc_d;
  logic [AW-1:0] idx_inc_d;
  logic [W-1:0]  first_vec_d;

  assign wr_acc_d  = WR_EN && !busy_q;
  assign idx_inc_d = idx_q + 1'b1;
  // A write to entry 0 in the same cycle as START must be visible as the
  // very first vector, so bypass the memory for that case.
  assign first_vec_d = (wr_acc_d && (WR_ADDR == '0)) ? WR_DATA : mem_q[0];

  // Pattern memory is deliberately not reset: contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_acc_d) begin
      mem_q[WR_ADDR] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      idx_q   <= '0;
      hcnt_q  <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (STOP) begin
      // STOP from any state returns to idle and wins over a coincident START.
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hcnt_q  <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            state_q <= ST_RUN;
            last_q  <= LAST;
            idx_q   <= '0;
            hcnt_q  <= '0;
            vec_q   <= first_vec_d;
            vld_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hcnt_q != HOLD_LAST) begin
            hcnt_q <= hcnt_q + 1'b1;
          end else begin
            // Final hold cycle of the current index: advance, wrap or finish.
            hcnt_q <= '0;
            if (idx_q < last_q) begin
              idx_q <= idx_inc_d;
              vec_q <= mem_q[idx_inc_d];
            end else if (LOOP) begin
              idx_q <= '0;
              vec_q <= mem_q[0];
            end else begin
              state_q <= ST_FIN;
              vec_q   <= '0;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign VEC       = vec_q;
  assign VEC_VALID = vld_q;
  assign IDX       = idx_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_digct_stim_seq.sv
// Bench for digct_stim_seq: randomized patterns compared with a time-based model.
// Latency: outputs sampled on the falling edge after each active edge.
// Backpressure: not applicable.
module tb_digct_stim_seq;

  localparam int HOLD = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [4:0] WR_ADDR;
  logic [4:0] WR_DATA;
  logic [4:0] LAST;
  logic       START;
  logic       STOP;
  logic       LOOP;
  logic [4:0] VEC;
  logic       VEC_VALID;
  logic [4:0] IDX;
  logic       BUSY;
  logic       DONE;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_mem [32];

  always #10 CLK = ~CLK;

  digct_stim_seq #(.DEPTH(32), .AW(5), .W(5), .HOLD(HOLD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .LAST      (LAST),
    .START     (START),
    .STOP      (STOP),
    .LOOP      (LOOP),
    .VEC       (VEC),
    .VEC_VALID (VEC_VALID),
    .IDX       (IDX),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  // {VEC, VEC_VALID, IDX, BUSY, DONE}
  function automatic logic [12:0] sample();
    return {VEC, VEC_VALID, IDX, BUSY, DONE};
  endfunction

  // Expected outputs t edges after the START edge. The run ends at the first
  // end-of-sequence boundary (a multiple of (L+1)*HOLD) at or after the edge
  // where LOOP is first seen low (toff); toff=0 means a plain one-shot run.
  function automatic logic [12:0] model(input int t, input int L, input int toff);
    int p;
    int n;
    int i;
    p = (L + 1) * HOLD;
    n = (toff + p - 1) / p;
    if (n < 1) n = 1;
    if (t >= n * p) return {5'd0, 1'b0, L[4:0], 1'b0, 1'b1};
    i = (t / HOLD) % (L + 1);
    return {exp_mem[i], 1'b1, i[4:0], 1'b1, 1'b0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Idle-only write; the model memory follows it.
  task automatic wr(input int addr, input logic [4:0] data);
    WR_EN   = 1'b1;
    WR_ADDR = addr[4:0];
    WR_DATA = data;
    tick();
    WR_EN = 1'b0;
    exp_mem[addr] = data;
  endtask

  // Pulse START and compare every cycle up to t=ncycles. A stray START is
  // pulsed before edge restart_t to show it is ignored while running.
  task automatic run_seq(input int L, input int ncycles, input int toff,
                         input int restart_t, input string name);
    logic [12:0] e;
    logic [12:0] o;
    LAST  = L[4:0];
    LOOP  = (toff > 0);
    START = 1'b1;
    for (int t = 0; t <= ncycles; t++) begin
      if (t > 0) begin
        LOOP  = (t < toff);
        START = (t == restart_t);
      end
      tick();
      if (t == 0) WR_EN = 1'b0;
      START = 1'b0;
      e = model(t, L, toff);
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s t=%0d got=%h exp=%h", name, t, o, e);
      end
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0; WR_EN = 0; WR_ADDR = 0; WR_DATA = 0;
    LAST = 0; START = 0; STOP = 0; LOOP = 0;
    #5;
    checks++;
    if (sample() !== 13'd0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", sample());
    end
    tick(); tick();
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (sample() !== 13'd0) begin
        errors++; $display("FAIL idle cyc=%0d got=%h exp=0", i, sample());
      end
    end
  endtask

  task automatic test_full_seq();
    for (int a = 0; a < 32; a++) wr(a, a[4:0]);
    run_seq(31, 70, 0, -1, "full_seq");
  endtask

  task automatic test_random_seq();
    int L;
    int p;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 8; k++) wr($urandom_range(0, 31), 5'($urandom));
      L = (it == 0) ? 0 : $urandom_range(0, 31);
      p = (L + 1) * HOLD;
      if (it % 2 == 1) begin
        run_seq(L, 3 * p, 1000000, 3, "rand_loop");
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        LOOP = 1'b0;
        checks++;
        if (sample() !== 13'd0) begin
          errors++; $display("FAIL rand_loop_stop got=%h exp=0", sample());
        end
      end else begin
        run_seq(L, p + 3, 0, 1, "rand_once");
      end
    end
  endtask

  task automatic test_loop();
    wr(0, 5'h15);
    wr(1, 5'h0A);
    run_seq(1, 24, 13, -1, "loop");
  endtask

  task automatic test_stop();
    run_seq(31, 14, 0, -1, "pre_stop");
    STOP = 1'b1; START = 1'b1;
    tick();
    STOP = 1'b0; START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sample() !== 13'd0) begin
        errors++; $display("FAIL stop_run cyc=%0d got=%h exp=0", i, sample());
      end
      tick();
    end
    run_seq(0, 3, 0, -1, "pre_stop_fin");
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    checks++;
    if (sample() !== 13'd0) begin
      errors++; $display("FAIL stop_fin got=%h exp=0", sample());
    end
  endtask

  task automatic test_write_bypass();
    run_seq(3, 3, 0, -1, "pre_drop");
    WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 5'h1F;
    tick();
    WR_EN = 1'b0;
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 5'h11;
    exp_mem[0] = 5'h11;
    run_seq(3, 9, 0, -1, "bypass");
    run_seq(2, 7, 0, -1, "rerun");
  endtask

  task automatic test_async_reset();
    for (int a = 0; a < 32; a++) wr(a, 5'($urandom));
    run_seq(31, 6, 0, -1, "pre_rst");
    #3 RST = 1'b0;
    #1;
    checks++;
    if (sample() !== 13'd0) begin
      errors++; $display("FAIL async_rst got=%h exp=0", sample());
    end
    @(negedge CLK);
    RST = 1'b1;
    tick();
    run_seq(31, 66, 0, -1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_full_seq();
    test_loop();
    test_stop();
    test_write_bypass();
    test_random_seq();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digct_stim_seq.md
# digct_stim_seq

Upstream vector sequencer for the DigCt circuit. It stores up to 32 five-bit input patterns and replays them on `VEC[4:0]`, which drives DigCt's `IN1`..`IN5` in hardware. Each vector is held for a programmable number of clock cycles. The default of 2 cycles matches the 40 ns per-vector cadence at a 20 ns clock. Run, stop and loop are controlled by the block, so DigCt can be exercised on silicon/FPGA without a simulator file load.

## Interface
Parameters:
- `DEPTH`, 32: pattern memory entries.
- `AW`, 5: address/index width, equal to clog2(DEPTH).
- `W`, 5: pattern width.
- `HOLD`, 2: cycles each vector is presented. Must be ≥1.

Ports:
- `CLK` in 1: single clock, rising-edge.
- `RST` in 1: asynchronous, active-low reset.
- `WR_EN` in 1: pattern write strobe. Accepted only when `BUSY`=0.
- `WR_ADDR` in AW: write address.
- `WR_DATA` in W: pattern data. Bit 4 maps to IN1 and bit 0 maps to IN5.
- `LAST` in AW: index of the final vector. Sampled on accepted START.
- `START` in 1: single-cycle start pulse.
- `STOP` in 1: single-cycle abort pulse.
- `LOOP` in 1: wrap to index 0 after `LAST` instead of finishing. Sampled at each end-of-sequence.
- `VEC` out W: current vector, `{IN1,IN2,IN3,IN4,IN5}`. Registered.
- `VEC_VALID` out 1: `VEC` is a live pattern.
- `IDX` out AW: index of the vector on `VEC`.
- `BUSY` out 1: sequencer in RUN.
- `DONE` out 1: non-loop sequence completed. Sticky until next START or STOP.

## Operation
- States:
  - IDLE: reset state.
  - RUN: replaying vectors.
  - FIN: non-loop sequence complete.
- Reset (RST=0, asynchronous, any state): the block enters IDLE. `VEC`=0, `VEC_VALID`=0, `IDX`=0, `BUSY`=0, `DONE`=0, hold counter=0. Memory contents are not reset and are retained across reset.
- IDLE/FIN + START (with STOP=0): go to RUN and latch `LAST`. `IDX`=0, `VEC`=mem[0], `VEC_VALID`=1, `BUSY`=1, `DONE`=0. The hold counter is cleared.
- RUN: each index is presented for exactly HOLD cycles. Then:
  - If `IDX`<`LAST`: `IDX`+1, and `VEC`=mem[`IDX`+1].
  - If `IDX`=`LAST` and LOOP=1: `IDX`=0, and `VEC`=mem[0]. There is no gap cycle.
  - If `IDX`=`LAST` and LOOP=0: go to FIN with `VEC`=0, `VEC_VALID`=0, `BUSY`=0, `DONE`=1. `IDX` keeps `LAST`.
- STOP in RUN or FIN: go to IDLE. `VEC`=0, `VEC_VALID`=0, `BUSY`=0, `DONE`=0, `IDX`=0.
- STOP and START in the same cycle: STOP wins and the block ends in IDLE.
- START while in RUN: ignored, with no restart.
- Writes:
  - `WR_EN` with `BUSY`=0 writes mem[`WR_ADDR`]=`WR_DATA` on that edge.
  - `WR_EN` with `BUSY`=1 is dropped with no effect.
  - `WR_EN` and an accepted START in the same cycle: the write commits, and if `WR_ADDR`=0 the first `VEC` shows the new `WR_DATA`. A write-first bypass is required.
- `LAST`=0: a single vector is presented for HOLD cycles, then FIN (or repeats every HOLD cycles if LOOP=1).
- `LAST`≥DEPTH is impossible for DEPTH=2^AW. Other DEPTH values are not supported.
- `IDX` increments modulo DEPTH. No other arithmetic is performed.

## Timing
- START sampled at edge k: `VEC`/`VEC_VALID`/`BUSY` are updated at edge k (visible cycle k..k+1). Latency is 1 edge.
- Vector i is first visible after edge k+i·HOLD and is stable for HOLD cycles.
- Non-loop completion: `DONE` rises at edge k+(LAST+1)·HOLD, in the same edge that `VEC_VALID` falls.
- STOP sampled at edge m: outputs are at idle values from edge m.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- Reset then idle, with no START for 10 cycles -> all outputs 0, and `BUSY` never rises.
- Write 32 patterns (data=addr), `LAST`=31, HOLD=2, LOOP=0, START -> `VEC` steps 0..31, each for 2 cycles. `DONE`=1 exactly 64 cycles after START and stays high. `VEC_VALID`=0 afterwards.
- Loop: patterns 5'h15/5'h0A, `LAST`=1, LOOP=1 -> sequence 15,15,0A,0A,15,... with no gap at the wrap. Deassert LOOP -> FIN after the next index-1 hold.
- STOP at vector 7 (with START pulsed the same cycle too) -> next edge IDLE, outputs 0, `DONE`=0, no restart.
- Write mem[0]=5'h1F while RUN (dropped) and mem[0]=5'h11 together with START from IDLE -> first `VEC`=5'h11. A subsequent run still shows 5'h11, not 5'h1F.
- Assert RST low mid-RUN at vector 3 -> outputs 0 immediately, without waiting for CLK. After release and START, the stored patterns replay unchanged.
